// File: rtl/eq1.sv
// eq1: unsigned operand comparator (eq/gt/lt) with a one-cycle registered result,
// valid strobe and sticky mismatch flag. Optional saturating match counter: EQ1_MATCH_CNT_EN.
module eq1 #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             in_valid,
  input  logic             clr,
  output logic             eq,
  output logic             gt,
  output logic             lt,
  output logic             eq_q,
  output logic             gt_q,
  output logic             lt_q,
  output logic             out_valid,
`ifdef EQ1_MATCH_CNT_EN
  output logic [CNT_W-1:0] match_cnt,
`endif
  output logic             mismatch
);

  if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
    $error("eq1: WIDTH must be in 1..64");
  end
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("eq1: CNT_W must be at least 1");
  end

  logic eq_s;
  logic gt_s;
  logic lt_s;

  // Unsigned magnitude compare; exactly one of the three flags is set.
  always_comb begin
    eq_s = 1'b0;
    gt_s = 1'b0;
    lt_s = 1'b0;
    if (i0 == i1) begin
      eq_s = 1'b1;
    end else if (i0 > i1) begin
      gt_s = 1'b1;
    end else begin
      lt_s = 1'b1;
    end
  end

  assign eq = eq_s;
  assign gt = gt_s;
  assign lt = lt_s;

  // Result stage: loads only on in_valid so idle-cycle operands never reach state.
  always_ff @(posedge clk) begin
    if (reset) begin
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      eq_q      <= eq_s;
      gt_q      <= gt_s;
      lt_q      <= lt_s;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  // Sticky mismatch; clr beats a same-edge mismatching sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch <= 1'b0;
    end else if (clr) begin
      mismatch <= 1'b0;
    end else if (in_valid && !eq_s) begin
      mismatch <= 1'b1;
    end else begin
      mismatch <= mismatch;
    end
  end

`ifdef EQ1_MATCH_CNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating count of valid equal samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      match_cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      match_cnt <= {CNT_W{1'b0}};
    end else if (in_valid && eq_s && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + CNT_ONE;
    end else begin
      match_cnt <= match_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_eq1.sv
// Self-checking bench for eq1: directed steps plus random traffic against a behavioural model.
module tb_eq1;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i0, i1;
  logic       in_valid, clr;
  logic       eq, gt, lt, eq_q, gt_q, lt_q, out_valid, mismatch;
`ifdef EQ1_MATCH_CNT_EN
  logic [1:0] match_cnt;
`endif

  logic       a1, b1;
  logic       eq1w, gt1w, lt1w, eq1q, gt1q, lt1q, ov1, mis1;
`ifdef EQ1_MATCH_CNT_EN
  logic [15:0] cnt1;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_eq, m_gt, m_lt, m_ov, m_mis, m_cnt;

  always #5 clk = ~clk;

  eq1 #(.WIDTH(8), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .i0(i0), .i1(i1), .in_valid(in_valid), .clr(clr),
    .eq(eq), .gt(gt), .lt(lt), .eq_q(eq_q), .gt_q(gt_q), .lt_q(lt_q),
    .out_valid(out_valid),
`ifdef EQ1_MATCH_CNT_EN
    .match_cnt(match_cnt),
`endif
    .mismatch(mismatch)
  );

  eq1 #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .i0(a1), .i1(b1), .in_valid(1'b0), .clr(1'b0),
    .eq(eq1w), .gt(gt1w), .lt(lt1w), .eq_q(eq1q), .gt_q(gt1q), .lt_q(lt1q),
    .out_valid(ov1),
`ifdef EQ1_MATCH_CNT_EN
    .match_cnt(cnt1),
`endif
    .mismatch(mis1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, " eq_q"}, {31'd0, eq_q}, m_eq);
    chk({tag, " gt_q"}, {31'd0, gt_q}, m_gt);
    chk({tag, " lt_q"}, {31'd0, lt_q}, m_lt);
    chk({tag, " out_valid"}, {31'd0, out_valid}, m_ov);
    chk({tag, " mismatch"}, {31'd0, mismatch}, m_mis);
`ifdef EQ1_MATCH_CNT_EN
    chk({tag, " match_cnt"}, {30'd0, match_cnt}, m_cnt);
`endif
  endtask

  // Drive one cycle of inputs, check comb outputs, clock, update model, check registers.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [7:0] a, input logic [7:0] b, input logic c);
    int ia, ib;
    @(negedge clk);
    reset = r; in_valid = v; i0 = a; i1 = b; clr = c;
    ia = int'(a); ib = int'(b);
    #1;
    chk({tag, " eq"}, {31'd0, eq}, (ia == ib) ? 1 : 0);
    chk({tag, " gt"}, {31'd0, gt}, (ia > ib) ? 1 : 0);
    chk({tag, " lt"}, {31'd0, lt}, (ia < ib) ? 1 : 0);
    @(posedge clk);
    if (r) begin
      m_eq = 0; m_gt = 0; m_lt = 0; m_ov = 0; m_mis = 0; m_cnt = 0;
    end else begin
      if (v) begin
        m_eq = (ia == ib) ? 1 : 0;
        m_gt = (ia > ib) ? 1 : 0;
        m_lt = (ia < ib) ? 1 : 0;
      end
      m_ov = v ? 1 : 0;
      if (c) m_mis = 0;
      else if (v && ia != ib) m_mis = 1;
      if (c) m_cnt = 0;
      else if (v && ia == ib && m_cnt < 3) m_cnt = m_cnt + 1;
    end
    #1;
    check_regs(tag);
  endtask

  initial begin
    logic [1:0] pat;
    reset = 1'b1; in_valid = 1'b0; clr = 1'b0; i0 = 8'd0; i1 = 8'd0; a1 = 1'b0; b1 = 1'b0;
    m_eq = 0; m_gt = 0; m_lt = 0; m_ov = 0; m_mis = 0; m_cnt = 0;

    step("reset0", 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step("reset1", 1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
    step("idle",   1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Width-1 truth table, each pattern held 10 ns
    for (int k = 0; k < 4; k++) begin
      pat = 2'(k);
      a1 = pat[1]; b1 = pat[0];
      #10;
      chk("w1 eq", {31'd0, eq1w}, (pat[1] == pat[0]) ? 1 : 0);
      chk("w1 gt", {31'd0, gt1w}, (pat[1] && !pat[0]) ? 1 : 0);
      chk("w1 lt", {31'd0, lt1w}, (!pat[1] && pat[0]) ? 1 : 0);
    end
    chk("w1 out_valid", {31'd0, ov1}, 0);
    chk("w1 mismatch", {31'd0, mis1}, 0);
    chk("w1 eq_q", {31'd0, eq1q | gt1q | lt1q}, 0);

    step("eq5a",    1'b0, 1'b1, 8'h5A, 8'h5A, 1'b0);
    step("eq5a+1",  1'b0, 1'b0, 8'h5A, 8'h5A, 1'b0);
    step("lt03",    1'b0, 1'b1, 8'h03, 8'h80, 1'b0);
    for (int k = 0; k < 3; k++) step("idle_mis", 1'b0, 1'b0, 8'hFF, 8'h00, 1'b0);
    step("clr",     1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    step("clr_mis", 1'b0, 1'b1, 8'hC0, 8'h0C, 1'b1);
    step("clr_cnt", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    for (int k = 0; k < 5; k++) step("sat", 1'b0, 1'b1, 8'(k * 7), 8'(k * 7), 1'b0);
    step("gt_b2b",  1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
    step("rst_mid", 1'b1, 1'b1, 8'h10, 8'h10, 1'b0);
    step("post_rst", 1'b0, 1'b0, 8'h10, 8'h10, 1'b0);

    for (int k = 0; k < 300; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 8'($urandom);
      step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
           ra, rb, ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eq1.md
# eq1

Equality comparator with a registered result stage. Its combinational `eq` output is 1 when inputs `i0` and `i1` are bitwise identical. It also provides greater-than and less-than flags, a one-cycle registered result with a valid strobe, and a sticky mismatch flag. It sits in the datapath wherever two operands need comparing, and is the base leaf for the wider comparator blocks.

## Interface
Parameters:
- `WIDTH`, default 1: operand width in bits; legal range 1..64.
- `CNT_W`, default 16: match-counter width; only used when `EQ1_MATCH_CNT_EN` is defined.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i0`, input, WIDTH: operand A, unsigned.
- `i1`, input, WIDTH: operand B, unsigned.
- `in_valid`, input, 1: qualifies `i0`/`i1` for the registered stage.
- `clr`, input, 1: synchronous clear of the sticky flag and the counter.
- `eq`, output, 1: combinational; 1 iff `i0 == i1`.
- `gt`, output, 1: combinational; 1 iff `i0 > i1` (unsigned).
- `lt`, output, 1: combinational; 1 iff `i0 < i1` (unsigned).
- `eq_q`, `gt_q`, `lt_q`, output, 1 each: registered copies of `eq`, `gt`, `lt`.
- `out_valid`, output, 1: 1 for exactly one cycle after a sampled `in_valid`.
- `mismatch`, output, 1: sticky; set by any valid sample with `i0 != i1`.
- `match_cnt`, output, CNT_W: saturating count of valid equal samples; present only with `EQ1_MATCH_CNT_EN`.

## Operation
- `eq`, `gt` and `lt` are purely combinational and do not depend on `clk` or `reset`.
- Exactly one of `eq`, `gt`, `lt` is 1 at any time.
- For WIDTH=1: `eq = ~(i0 ^ i1)`, so 00 gives 1, 01 gives 0, 10 gives 0, 11 gives 1.
- Registered stage, on a rising edge with `in_valid` = 1:
  - `eq_q`, `gt_q`, `lt_q` load the current combinational values.
  - `out_valid` goes to 1.
- Registered stage, on a rising edge with `in_valid` = 0:
  - `out_valid` goes to 0.
  - `eq_q`, `gt_q`, `lt_q` hold their values.
- `mismatch`:
  - Set on an edge where `in_valid` = 1 and `eq` = 0.
  - Cleared by `reset` or `clr`.
  - Simultaneous `clr` and a mismatching valid sample: `clr` wins, and `mismatch` = 0 the next cycle.
- `match_cnt`:
  - Increments by 1 on each edge where `in_valid` = 1 and `eq` = 1.
  - Saturates at 2^CNT_W−1; no wrap-around.
  - `clr` has priority over increment.
- `reset` has priority over `clr` and `in_valid`.
- Inputs are sampled only on `in_valid`; X on `i0`/`i1` while `in_valid` = 0 must not corrupt any state.

## Timing
- Combinational path: `i0`/`i1` to `eq`/`gt`/`lt`, zero cycles, settled within the same cycle.
- Registered latency is 1 cycle: `in_valid` sampled at edge N makes the result visible after edge N and valid until edge N+1.
- No backpressure; a new sample may be accepted every cycle.
- Reset values, after an edge with `reset` = 1:
  - `eq_q` = 0, `gt_q` = 0, `lt_q` = 0.
  - `out_valid` = 0, `mismatch` = 0, `match_cnt` = 0.
- Reset asserted mid-stream:
  - The sample presented on the reset edge is discarded.
  - `out_valid` = 0 on the following cycle.

## Configuration
- `EQ1_MATCH_CNT_EN` defined: `match_cnt` port and counter logic are present as described above.
- `EQ1_MATCH_CNT_EN` undefined: no `match_cnt` port and no counter registers. All other behaviour is identical.

## Test plan
- WIDTH=1, no clock activity, apply (i0,i1) = 00, 01, 10, 11 holding each 10 ns -> `eq` = 1, 0, 0, 1; `gt` = 0, 0, 1, 0; `lt` = 0, 1, 0, 0.
- Reset for 2 cycles, then release -> all registered outputs 0, `match_cnt` = 0.
- WIDTH=8, `in_valid` pulse with i0=8'h5A, i1=8'h5A -> next cycle `eq_q`=1, `out_valid`=1 for one cycle, `match_cnt`=1.
- WIDTH=8, valid sample i0=8'h03, i1=8'h80 -> `lt_q`=1, `mismatch`=1. Follow with 3 idle cycles -> `mismatch` stays 1. Then `clr` -> `mismatch`=0.
- Same edge: `clr`=1 plus a mismatching valid sample -> `mismatch`=0 and `out_valid`=1 next cycle.
- CNT_W=2 with macro defined, 5 consecutive valid equal samples -> `match_cnt` reads 1, 2, 3, 3, 3 (saturates).
